// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with default-master parking and locked transfers.
// Define ARB_BURST_HOLD_EN to hold the grant until the last beat of fixed bursts.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam logic [IW-1:0] DEF = IW'(DEFAULT_MASTER);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_INCR   = 3'b001;

`ifdef ARB_BURST_HOLD_EN
    typedef enum logic [1:0] {PARK, OWN, BURST, LOCK} state_t;
    logic [3:0] cnt, cnt_nx, burst_len;
`else
    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;
`endif

    state_t        state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [IW-1:0] rr, rr_nx;
    logic [IW-1:0] win, idx;
    logic          win_ok;
    logic          force_arb, force_nx;
    logic          arb;

    // Round-robin search starting just after the last winner
    always_comb begin
        win    = DEF;
        win_ok = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = IW'((int'(rr) + i) % NUM_MASTERS);
            if (!win_ok && HBUSREQ[idx]) begin
                win    = idx;
                win_ok = 1'b1;
            end
        end
    end

`ifdef ARB_BURST_HOLD_EN
    always_comb begin
        unique case (HBURST)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase
    end
`endif

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr;
        force_nx = force_arb;
        arb      = 1'b0;
`ifdef ARB_BURST_HOLD_EN
        cnt_nx   = cnt;
`endif
        if (!HREADY) begin
            // Non-OKAY response: abandon the burst, re-arbitrate when it completes
            if (HRESP != 2'b00) begin
                force_nx = 1'b1;
`ifdef ARB_BURST_HOLD_EN
                cnt_nx   = '0;
`endif
            end
        end else begin
            force_nx = 1'b0;
            unique case (state)
                PARK, OWN: begin
                    if (HLOCK[owner]) begin
                        state_nx = LOCK;
                    end else if (force_arb) begin
                        arb = 1'b1;
`ifdef ARB_BURST_HOLD_EN
                    end else if (HTRANS == T_NONSEQ && burst_len != 4'd0) begin
                        state_nx = BURST;
                        cnt_nx   = burst_len;
`endif
                    end else if (HTRANS == T_BUSY) begin
                        state_nx = OWN;
                    end else if (HBURST == B_INCR && HTRANS != T_IDLE
                                 && HBUSREQ[owner]) begin
                        state_nx = OWN;
                    end else begin
                        arb = 1'b1;
                    end
                end
`ifdef ARB_BURST_HOLD_EN
                BURST: begin
                    if (HLOCK[owner]) begin
                        state_nx = LOCK;
                    end else if (force_arb) begin
                        arb = 1'b1;
                    end else begin
                        unique case (HTRANS)
                            T_SEQ: begin
                                if (cnt <= 4'd1) arb = 1'b1;
                                else cnt_nx = cnt - 4'd1;
                            end
                            T_NONSEQ: begin
                                if (burst_len != 4'd0) cnt_nx = burst_len;
                                else arb = 1'b1;
                            end
                            T_BUSY: state_nx = BURST;
                            default: arb = 1'b1;
                        endcase
                    end
                end
`endif
                LOCK: begin
                    // Owner keeps the bus for one more edge after unlocking
                    if (!HLOCK[owner]) begin
                        state_nx = OWN;
`ifdef ARB_BURST_HOLD_EN
                        cnt_nx   = '0;
`endif
                    end
                end
                default: arb = 1'b1;
            endcase
            if (arb) begin
                state_nx = win_ok ? OWN : PARK;
                owner_nx = win;
                if (win_ok) rr_nx = win;
`ifdef ARB_BURST_HOLD_EN
                cnt_nx   = '0;
`endif
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= PARK;
            owner     <= DEF;
            rr        <= DEF;
            force_arb <= 1'b0;
`ifdef ARB_BURST_HOLD_EN
            cnt       <= '0;
`endif
            HGRANT    <= NUM_MASTERS'(1) << DEF;
            HMASTER   <= 4'(DEF);
            HMASTLOCK <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            rr        <= rr_nx;
            force_arb <= force_nx;
`ifdef ARB_BURST_HOLD_EN
            cnt       <= cnt_nx;
`endif
            HGRANT    <= NUM_MASTERS'(1) << owner_nx;
            if (HREADY) begin
                HMASTER   <= 4'(owner);
                HMASTLOCK <= HLOCK[owner];
            end
        end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed vector bench for ahb_bus_arbiter (4 masters, default master 0).
module tb_ahb_bus_arbiter;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;
    localparam logic [2:0] SNG  = 3'b000;
    localparam logic [2:0] INC  = 3'b001;
    localparam logic [2:0] INC4 = 3'b011;
    localparam logic [2:0] INC8 = 3'b101;
    localparam logic [1:0] OK   = 2'b00;
    localparam logic [1:0] SPL  = 2'b11;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HRESP;
    logic [3:0] HGRANT;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [1:0] resp;
        logic [3:0] grant;
        logic [3:0] master;
        logic       mlock;
    } vec_t;

    vec_t vecs[$];

    ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .HBUSREQ(HBUSREQ),
        .HLOCK(HLOCK),
        .HTRANS(HTRANS),
        .HBURST(HBURST),
        .HREADY(HREADY),
        .HRESP(HRESP),
        .HGRANT(HGRANT),
        .HMASTER(HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic vec_t mk(input string n, input logic rst,
                                input logic [3:0] req, input logic [3:0] lock,
                                input logic [1:0] tr, input logic [2:0] bu,
                                input logic rdy, input logic [1:0] rsp,
                                input logic [3:0] g, input logic [3:0] m,
                                input logic ml);
        vec_t t;
        t.name = n; t.rst = rst; t.req = req; t.lock = lock;
        t.trans = tr; t.burst = bu; t.rdy = rdy; t.resp = rsp;
        t.grant = g; t.master = m; t.mlock = ml;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        HRESET  = t.rst;
        HBUSREQ = t.req;
        HLOCK   = t.lock;
        HTRANS  = t.trans;
        HBURST  = t.burst;
        HREADY  = t.rdy;
        HRESP   = t.resp;
        @(posedge HCLK);
        #1;
        total++;
        if (HGRANT === t.grant && HMASTER === t.master && HMASTLOCK === t.mlock)
            passed++;
        else
            $display("FAIL %s: got grant=%b master=%0d mlock=%b, required grant=%b master=%0d mlock=%b",
                     t.name, HGRANT, HMASTER, HMASTLOCK, t.grant, t.master, t.mlock);
        total++;
        if ($onehot(HGRANT))
            passed++;
        else
            $display("FAIL %s_onehot: got grant=%b, required exactly one bit set",
                     t.name, HGRANT);
    endtask

    initial begin
        vecs.push_back(mk("rst0",   1, 4'b0000, 4'b0000, IDLE, SNG, 1, OK, 4'b0001, 0, 0));
        vecs.push_back(mk("rst1",   1, 4'b0000, 4'b0000, IDLE, SNG, 1, OK, 4'b0001, 0, 0));
        vecs.push_back(mk("park",   0, 4'b0000, 4'b0000, IDLE, SNG, 1, OK, 4'b0001, 0, 0));
        vecs.push_back(mk("rr1",    0, 4'b1111, 4'b0000, NSEQ, SNG, 1, OK, 4'b0010, 0, 0));
        vecs.push_back(mk("rr2",    0, 4'b1111, 4'b0000, NSEQ, SNG, 1, OK, 4'b0100, 1, 0));
        vecs.push_back(mk("rr3",    0, 4'b1111, 4'b0000, NSEQ, SNG, 1, OK, 4'b1000, 2, 0));
        vecs.push_back(mk("rr4",    0, 4'b1111, 4'b0000, NSEQ, SNG, 1, OK, 4'b0001, 3, 0));
        vecs.push_back(mk("rr5",    0, 4'b1111, 4'b0000, NSEQ, SNG, 1, OK, 4'b0010, 0, 0));
        vecs.push_back(mk("to_m2",  0, 4'b0110, 4'b0000, IDLE, SNG, 1, OK, 4'b0100, 1, 0));
`ifdef ARB_BURST_HOLD_EN
        vecs.push_back(mk("bh1",    0, 4'b0110, 4'b0000, NSEQ, INC4, 1, OK, 4'b0100, 2, 0));
        vecs.push_back(mk("bh2",    0, 4'b0110, 4'b0000, SEQ,  INC4, 1, OK, 4'b0100, 2, 0));
        vecs.push_back(mk("bh_wait",0, 4'b0110, 4'b0000, SEQ,  INC4, 0, OK, 4'b0100, 2, 0));
        vecs.push_back(mk("bh3",    0, 4'b0110, 4'b0000, SEQ,  INC4, 1, OK, 4'b0100, 2, 0));
        vecs.push_back(mk("bh4",    0, 4'b0110, 4'b0000, SEQ,  INC4, 1, OK, 4'b0010, 2, 0));
`else
        vecs.push_back(mk("brk",    0, 4'b0110, 4'b0000, NSEQ, INC4, 1, OK, 4'b0010, 2, 0));
`endif
        vecs.push_back(mk("incr1",  0, 4'b0110, 4'b0000, NSEQ, INC, 1, OK, 4'b0010, 1, 0));
        vecs.push_back(mk("incr2",  0, 4'b0110, 4'b0000, SEQ,  INC, 1, OK, 4'b0010, 1, 0));
        vecs.push_back(mk("incr_end",0,4'b0100, 4'b0000, SEQ,  INC, 1, OK, 4'b0100, 1, 0));
        vecs.push_back(mk("busy",   0, 4'b0011, 4'b0000, BUSY, SNG, 1, OK, 4'b0100, 2, 0));
        vecs.push_back(mk("idle",   0, 4'b0000, 4'b0000, IDLE, SNG, 1, OK, 4'b0001, 2, 0));
        vecs.push_back(mk("park2",  0, 4'b0000, 4'b0000, IDLE, SNG, 1, OK, 4'b0001, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Locked sequence: M3 locks for six transfers while M0 waits
        apply(mk("lk_win",  0, 4'b1001, 4'b1000, IDLE, SNG, 1, OK, 4'b1000, 0, 0));
        for (int i = 0; i < 6; i++)
            apply(mk($sformatf("lk_hold%0d", i), 0, 4'b1001, 4'b1000, NSEQ, SNG,
                     (i == 2) ? 1'b0 : 1'b1, OK, 4'b1000, 3, 1));
        apply(mk("lk_fall", 0, 4'b1001, 4'b0000, NSEQ, SNG, 1, OK, 4'b1000, 3, 0));
        apply(mk("lk_rel",  0, 4'b1001, 4'b0000, NSEQ, SNG, 1, OK, 4'b0001, 3, 0));

        // SPLIT in the middle of an INCR8 from M1
        apply(mk("s_own",   0, 4'b0010, 4'b0000, IDLE, SNG,  1, OK,  4'b0010, 0, 0));
        apply(mk("s_b1",    0, 4'b0010, 4'b0000, NSEQ, INC8, 1, OK,  4'b0010, 1, 0));
        apply(mk("s_b2",    0, 4'b0010, 4'b0000, SEQ,  INC8, 1, OK,  4'b0010, 1, 0));
        apply(mk("s_b3",    0, 4'b0010, 4'b0000, SEQ,  INC8, 1, OK,  4'b0010, 1, 0));
        apply(mk("s_wait",  0, 4'b0110, 4'b0000, SEQ,  INC8, 0, SPL, 4'b0010, 1, 0));
        apply(mk("s_arb",   0, 4'b0110, 4'b0000, IDLE, INC8, 1, SPL, 4'b0100, 1, 0));

        // Reset in the middle of an INCR8 from M2
        apply(mk("r_b1",    0, 4'b0100, 4'b0000, NSEQ, INC8, 1, OK, 4'b0100, 2, 0));
        apply(mk("r_b2",    0, 4'b0100, 4'b0000, SEQ,  INC8, 1, OK, 4'b0100, 2, 0));
        apply(mk("r_rst",   1, 4'b0100, 4'b0000, SEQ,  INC8, 1, OK, 4'b0001, 0, 0));
        apply(mk("r_after", 0, 4'b0100, 4'b0000, SEQ,  INC8, 1, OK, 4'b0100, 0, 0));
        apply(mk("r_end",   0, 4'b0000, 4'b0000, IDLE, SNG,  1, OK, 4'b0001, 2, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
